// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
// Imported by the receiver sub-module and the loader top.
package uart_prog_loader_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    typedef enum logic [1:0] {
        LD_LOAD,
        LD_DRAIN,
        LD_DONE
    } ld_state_e;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_FRAME   = 3'd1,
        ERR_OVERRUN = 3'd2,
        ERR_TIMEOUT = 3'd3,
        ERR_FULL    = 3'd4
    } err_code_e;

    localparam int unsigned MIN_CPB = 4;

endpackage

// File: rtl/uart_prog_loader_rx.sv
// 8N1 UART receiver with a 2-flop input synchroniser and a per-frame latched bit period.
// Emits a one-cycle byte_valid_o or frame_err_o at the end of each frame.
module uart_prog_loader_rx
    import uart_prog_loader_pkg::*;
#(
    parameter int unsigned CPB_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [CPB_W-1:0] clks_per_bit_i,
    input  logic             rx_i,
    output logic             byte_valid_o,
    output logic [7:0]       byte_o,
    output logic             frame_err_o,
    output logic             idle_o
);

    rx_state_e        state_q, state_d;
    logic             rxMeta_q, rxSync_q;
    logic [CPB_W-1:0] cnt_q, cnt_d;
    logic [CPB_W-1:0] cpb_q, cpb_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byteValid_q, byteValid_d;
    logic             frameErr_q, frameErr_d;
    logic [CPB_W-1:0] cpbLast;

    assign cpbLast = cpb_q - CPB_W'(1);

    // The synchroniser idles high and is deliberately untouched by the soft clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= rx_i;
            rxSync_q <= rxMeta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cpb_d       = cpb_q;
        bitIdx_d    = bitIdx_q;
        shift_d     = shift_q;
        byteValid_d = 1'b0;
        frameErr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d    = '0;
                bitIdx_d = '0;
                if (!rxSync_q) begin
                    state_d = RX_START;
                    cpb_d   = (clks_per_bit_i < CPB_W'(MIN_CPB)) ? CPB_W'(MIN_CPB) : clks_per_bit_i;
                end
            end
            RX_START: begin
                if (cnt_q == (cpb_q >> 1)) begin
                    cnt_d   = '0;
                    state_d = rxSync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CPB_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == cpbLast) begin
                    cnt_d    = '0;
                    shift_d  = {rxSync_q, shift_q[7:1]};
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CPB_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == cpbLast) begin
                    cnt_d = '0;
                    if (rxSync_q) begin
                        byteValid_d = 1'b1;
                        state_d     = RX_IDLE;
                    end else begin
                        frameErr_d = 1'b1;
                        state_d    = RX_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CPB_W'(1);
                end
            end
            RX_WAIT_HIGH: begin
                if (rxSync_q) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            cpb_q       <= '0;
            bitIdx_q    <= '0;
            shift_q     <= '0;
            byteValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
        end else if (!en_i) begin
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            cpb_q       <= '0;
            bitIdx_q    <= '0;
            shift_q     <= '0;
            byteValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cpb_q       <= cpb_d;
            bitIdx_q    <= bitIdx_d;
            shift_q     <= shift_d;
            byteValid_q <= byteValid_d;
            frameErr_q  <= frameErr_d;
        end
    end

    assign byte_valid_o = byteValid_q;
    assign byte_o       = shift_q;
    assign frame_err_o  = frameErr_q;
    assign idle_o       = (state_q == RX_IDLE);

endmodule

// File: rtl/uart_prog_loader.sv
// UART boot loader: assembles little-endian words from the RX stream and writes them to
// instruction memory through a req/gnt port, releasing the core once the load ends.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 10,
    parameter logic [31:0] SENTINEL       = 32'h00000FFF,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned CPB_W          = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [CPB_W-1:0]  clks_per_bit_i,
    input  logic              rx_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    output logic              done_o,
    output logic              core_rst_no,
    output logic [ADDR_W:0]   word_cnt_o,
    output logic              err_o,
    output logic [2:0]        err_code_o
);

    localparam int unsigned       BYTES      = DATA_W / 8;
    localparam int unsigned       IDX_W      = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(BYTES - 1);
    localparam logic [DATA_W-1:0] SENT_WORD  = DATA_W'(SENTINEL);
    localparam logic [ADDR_W:0]   DEPTH_LAST = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [31:0]       TO_LAST    = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    logic       rxValid, rxFrameErr, rxIdle;
    logic [7:0] rxByte;

    uart_prog_loader_rx #(.CPB_W(CPB_W)) u_rx (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .en_i          (en_i),
        .clks_per_bit_i(clks_per_bit_i),
        .rx_i          (rx_i),
        .byte_valid_o  (rxValid),
        .byte_o        (rxByte),
        .frame_err_o   (rxFrameErr),
        .idle_o        (rxIdle)
    );

    ld_state_e         ldState_q, ldState_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic [IDX_W-1:0]  byteIdx_q, byteIdx_d;
    logic              pendValid_q, pendValid_d;
    logic [DATA_W-1:0] pendData_q, pendData_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   wordCnt_q, wordCnt_d;
    logic [31:0]       idleCnt_q, idleCnt_d;
    logic              err_q, err_d;
    err_code_e         errCode_q, errCode_d;

    err_code_e         newErr;
    logic [DATA_W-1:0] wordNext;
    logic              gntFire, fullNow, pendBusy;

    // A grant in the same cycle as word completion frees the pending slot first.
    always_comb begin
        ldState_d   = ldState_q;
        asm_d       = asm_q;
        byteIdx_d   = byteIdx_q;
        pendValid_d = pendValid_q;
        pendData_d  = pendData_q;
        addr_d      = addr_q;
        wordCnt_d   = wordCnt_q;
        idleCnt_d   = '0;
        err_d       = err_q;
        errCode_d   = errCode_q;
        newErr      = ERR_NONE;
        wordNext    = asm_q;
        wordNext[8*byteIdx_q +: 8] = rxByte;
        gntFire     = pendValid_q && mem_gnt_i;
        fullNow     = gntFire && (wordCnt_q == DEPTH_LAST);
        pendBusy    = pendValid_q && !gntFire;

        if (gntFire) begin
            pendValid_d = 1'b0;
            addr_d      = addr_q + ADDR_W'(1);
            wordCnt_d   = wordCnt_q + (ADDR_W+1)'(1);
            if (fullNow) begin
                ldState_d = LD_DONE;
                newErr    = ERR_FULL;
            end else if (ldState_q == LD_DRAIN) begin
                ldState_d = LD_DONE;
            end
        end

        if (ldState_q == LD_LOAD && !fullNow) begin
            if (rxFrameErr) begin
                newErr = ERR_FRAME;
            end else if (rxValid) begin
                if (byteIdx_q == LAST_IDX) begin
                    byteIdx_d = '0;
                    asm_d     = '0;
                    if (wordNext == SENT_WORD) begin
                        ldState_d = pendBusy ? LD_DRAIN : LD_DONE;
                    end else if (pendBusy) begin
                        newErr = ERR_OVERRUN;
                    end else begin
                        pendValid_d = 1'b1;
                        pendData_d  = wordNext;
                    end
                end else begin
                    asm_d     = wordNext;
                    byteIdx_d = byteIdx_q + IDX_W'(1);
                end
            end else if (TIMEOUT_CYCLES != 0 && byteIdx_q != '0 && rxIdle) begin
                if (idleCnt_q == TO_LAST) begin
                    asm_d     = '0;
                    byteIdx_d = '0;
                    newErr    = ERR_TIMEOUT;
                end else begin
                    idleCnt_d = idleCnt_q + 32'd1;
                end
            end
        end

        if (newErr != ERR_NONE) begin
            err_d = 1'b1;
            if (!err_q) begin
                errCode_d = newErr;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ldState_q   <= LD_LOAD;
            asm_q       <= '0;
            byteIdx_q   <= '0;
            pendValid_q <= 1'b0;
            pendData_q  <= '0;
            addr_q      <= '0;
            wordCnt_q   <= '0;
            idleCnt_q   <= '0;
            err_q       <= 1'b0;
            errCode_q   <= ERR_NONE;
        end else if (!en_i) begin
            ldState_q   <= LD_LOAD;
            asm_q       <= '0;
            byteIdx_q   <= '0;
            pendValid_q <= 1'b0;
            pendData_q  <= '0;
            addr_q      <= '0;
            wordCnt_q   <= '0;
            idleCnt_q   <= '0;
            err_q       <= 1'b0;
            errCode_q   <= ERR_NONE;
        end else begin
            ldState_q   <= ldState_d;
            asm_q       <= asm_d;
            byteIdx_q   <= byteIdx_d;
            pendValid_q <= pendValid_d;
            pendData_q  <= pendData_d;
            addr_q      <= addr_d;
            wordCnt_q   <= wordCnt_d;
            idleCnt_q   <= idleCnt_d;
            err_q       <= err_d;
            errCode_q   <= errCode_d;
        end
    end

    assign mem_req_o   = pendValid_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = pendData_q;
    assign done_o      = (ldState_q == LD_DONE);
    assign core_rst_no = done_o;
    assign word_cnt_o  = wordCnt_q;
    assign err_o       = err_q;
    assign err_code_o  = errCode_q;

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Parametrised UART program loader: receives a byte stream on a UART RX line and assembles little-endian words of DATA_W bits.
- Writes each word through a req/gnt port into instruction memory at incrementing word addresses.
- Holds the core in reset until a sentinel word or the memory depth ends the load.
- Successor to the fixed 32-bit / fixed-baud boot path: adds runtime baud, generic width/depth, timeout, backpressure and error reporting.

Parameters:
DATA_W, 32, word width; multiple of 8; BYTES = DATA_W/8
ADDR_W, 10, word-address width; DEPTH = 2**ADDR_W
SENTINEL, 32'h00000FFF (zero-extended to DATA_W), end-of-program word; never written
TIMEOUT_CYCLES, 0, inter-byte idle limit within a partial word; 0 disables
CPB_W, 16, width of clks_per_bit_i

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
en_i  in  1  loader enable; low acts as soft clear
clks_per_bit_i  in  CPB_W  clock cycles per UART bit (e.g. 87)
rx_i  in  1  UART serial input, idle high, 8N1, LSB first
mem_req_o  out  1  write request
mem_addr_o  out  ADDR_W  word address
mem_wdata_o  out  DATA_W  write data
mem_gnt_i  in  1  write accepted this cycle
done_o  out  1  load finished (sticky)
core_rst_no  out  1  core reset release; equals done_o
word_cnt_o  out  ADDR_W+1  words written so far
err_o  out  1  sticky error flag
err_code_o  out  3  first error: 0 NONE, 1 FRAME, 2 OVERRUN, 3 TIMEOUT, 4 FULL

Behaviour:
- Reset values: all outputs 0. Synchroniser flops reset to 1. Address, byte index and counters reset to 0.
- RX path: 2-flop synchroniser on rx_i.
- clks_per_bit is latched on start-bit detect; values below 4 are clamped to 4.
- RX FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE->START on synced rx = 0.
  - START: at cpb/2 re-sample; if 1 (glitch) -> IDLE, else -> DATA.
  - DATA: sample every cpb cycles, 8 bits, LSB first.
  - STOP: sample after cpb cycles. If 1: 1-cycle byte_valid, -> IDLE. If 0: FRAME error, byte dropped, -> WAIT_HIGH.
  - WAIT_HIGH -> IDLE once rx = 1.
- Assembler: byte k is placed in bits [8k+7:8k].
  - On byte BYTES-1 completing a word: if word == SENTINEL -> DONE (no write); else queue the word for write.
  - Words from the last byte are therefore never lost.
- Write port: req is held with addr/wdata stable until gnt; gnt is allowed in the same cycle as req rise.
  - On gnt: addr+1, word_cnt+1, req drops the next cycle unless a queued word is pending.
- Buffering: one pending-write register plus the assembly shift register.
  - If a new word completes while a write is still pending: OVERRUN error, new word dropped.
- Depth: after the DEPTH-th grant -> DONE with FULL code; later bytes are ignored.
- Timeout: when byte index != 0 and TIMEOUT_CYCLES != 0, an idle counter runs while RX is in IDLE.
  - On reaching TIMEOUT_CYCLES: partial word discarded, byte index = 0, TIMEOUT error, loading continues.
- Errors: err_o sticky; err_code_o holds the first error only; FULL is recorded only if no earlier error.
- DONE: done_o = core_rst_no = 1, held until reset or en_i low; RX bytes are ignored.
- en_i low: next cycle, all state except the synchroniser returns to reset values, including errors and done.
  - While en_i is low, RX bytes are ignored.
- Simultaneous gnt and word completion: the grant frees the pending register first, so no overrun.
- Async reset mid-byte or mid-write: immediate return to reset values; req drops asynchronously.

Decomposition:
- Package uart_prog_loader_pkg:
  - rx_state_e and ld_state_e enums
  - err_code_e (NONE, FRAME, OVERRUN, TIMEOUT, FULL)
  - MIN_CPB = 4 constant
- Sub-module uart_prog_loader_rx: synchroniser, RX FSM, byte_valid/byte/frame_err outputs.
- Top: assembler, write port, timeout and error logic.

Test Plan:
- cpb=87, gnt tied 1; send 13 05 00 00, 93 05 10 00, FF 0F 00 00 -> writes 0x00000513@0, 0x00100593@1; done_o=1, word_cnt=2, err_o=0.
- Byte 0xA5 sent with stop bit 0 -> err_code=FRAME, no byte_valid; next valid word is still written at addr 0.
- gnt held 0 for 2 full words -> first word pending, second word dropped, err_code=OVERRUN; after gnt, exactly 1 write occurs.
- TIMEOUT_CYCLES=5000; send 2 bytes, idle 6000 cycles -> err_code=TIMEOUT; next 4 bytes form a full word written at addr 0.
- ADDR_W=2; send 5 non-sentinel words -> 4 writes (addr 0..3), done_o=1, err_code=FULL, 5th word ignored.
- rst_ni pulsed low mid-DATA of byte 2 -> all outputs 0; a fresh 4-byte word loads at addr 0.
